time_counter: RTL

//   Timekeeping core of the clock: divides the system clock down to a 1 Hz tick and keeps
//   HH:MM:SS as six registered BCD digits (24 h format). Each digit output feeds one

---
 rtl/time_counter_pkg.sv | 20 ++
 rtl/time_counter_if.sv | 46 ++++
 rtl/time_counter_bcd_mod_counter.sv | 37 +++
 rtl/time_counter.sv | 88 ++++++++
 4 files changed

// File: rtl/time_counter_pkg.sv
// Shared clock-core types and limits: BCD digit type, per-field maxima and their
// tens/ones split used to parameterise the two-digit counters.
package time_counter_pkg;

   typedef logic [3:0] bcd_t;

   localparam int   SEC_MAX  = 59;
   localparam int   MIN_MAX  = 59;
   localparam int   HOUR_MAX = 23;
   localparam bcd_t BCD_ZERO = 4'd0;
   localparam bcd_t BCD_NINE = 4'd9;

   localparam bcd_t SEC_MAX_TENS  = bcd_t'(SEC_MAX / 10);
   localparam bcd_t SEC_MAX_ONES  = bcd_t'(SEC_MAX % 10);
   localparam bcd_t MIN_MAX_TENS  = bcd_t'(MIN_MAX / 10);
   localparam bcd_t MIN_MAX_ONES  = bcd_t'(MIN_MAX % 10);
   localparam bcd_t HOUR_MAX_TENS = bcd_t'(HOUR_MAX / 10);
   localparam bcd_t HOUR_MAX_ONES = bcd_t'(HOUR_MAX % 10);

endpackage

// File: rtl/time_counter_if.sv
// Control inputs and display outputs of the timekeeping core.
// ALARM_EN adds the alarm store/arm inputs and the alarm_hit output.
interface time_counter_if;
   import time_counter_pkg::*;

   logic run;
   logic set_min_inc;
   logic set_hour_inc;
   bcd_t hour_tens;
   bcd_t hour_ones;
   bcd_t min_tens;
   bcd_t min_ones;
   bcd_t sec_tens;
   bcd_t sec_ones;
   logic tick_1hz;
   logic colon;

`ifdef ALARM_EN
   logic alarm_store;
   logic alarm_arm;
   logic alarm_hit;

   modport master (
      output run, set_min_inc, set_hour_inc, alarm_store, alarm_arm,
      input  hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
      input  tick_1hz, colon, alarm_hit
   );
   modport slave (
      input  run, set_min_inc, set_hour_inc, alarm_store, alarm_arm,
      output hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
      output tick_1hz, colon, alarm_hit
   );
`else
   modport master (
      output run, set_min_inc, set_hour_inc,
      input  hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
      input  tick_1hz, colon
   );
   modport slave (
      input  run, set_min_inc, set_hour_inc,
      output hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
      output tick_1hz, colon
   );
`endif

endinterface

// File: rtl/time_counter_bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MAX_TENS:MAX_ONES back to 00.
// carry is combinational so a chain of these advances in a single cycle.
module bcd_mod_counter
   import time_counter_pkg::*;
#(
   parameter bcd_t MAX_TENS = 4'd5,
   parameter bcd_t MAX_ONES = 4'd9
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output bcd_t tens,
   output bcd_t ones,
   output logic carry
);

   logic at_max;

   assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
   assign carry  = inc && !clr && at_max;

   always_ff @(posedge clk) begin
      if (rst || clr || (inc && at_max)) begin
         tens <= BCD_ZERO;
         ones <= BCD_ZERO;
      end else if (inc) begin
         if (ones == BCD_NINE) begin
            ones <= BCD_ZERO;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/time_counter.sv
// HH:MM:SS timekeeping core: 1 Hz prescaler, BCD second/minute/hour counters, set path.
// Optional alarm comparator is built when ALARM_EN is defined.
module time_counter
   import time_counter_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000
) (
   input logic           clk,
   input logic           rst,
   time_counter_if.slave bus
);

   localparam int             PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRE_TC    = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]  COLON_LIM = PW'(CLK_HZ - CLK_HZ / 2);

   // Prescaler runs downward: pre_cnt == CLK_HZ-1-(elapsed cycles in this second)
   logic [PW-1:0] pre_cnt;
   logic          set_any;
   logic          tick_now;
   logic          tick_q;
   logic          sec_carry;
   logic          min_carry;
   logic          hour_carry_unused;
   logic          min_inc;
   logic          hour_inc;

   assign set_any  = bus.set_min_inc || bus.set_hour_inc;
   assign tick_now = bus.run && (pre_cnt == '0) && !set_any;
   assign min_inc  = sec_carry || bus.set_min_inc;
   // Minute set wraps 59->00 without touching hours
   assign hour_inc = (min_carry && !bus.set_min_inc) || bus.set_hour_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= PRE_TC;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= tick_now;
         if (set_any) begin
            pre_cnt <= PRE_TC;
         end else if (bus.run) begin
            pre_cnt <= (pre_cnt == '0) ? PRE_TC : pre_cnt - 1'b1;
         end
      end
   end

   bcd_mod_counter #(.MAX_TENS(SEC_MAX_TENS), .MAX_ONES(SEC_MAX_ONES)) u_sec (
      .clk(clk), .rst(rst), .inc(tick_now), .clr(set_any),
      .tens(bus.sec_tens), .ones(bus.sec_ones), .carry(sec_carry)
   );

   bcd_mod_counter #(.MAX_TENS(MIN_MAX_TENS), .MAX_ONES(MIN_MAX_ONES)) u_min (
      .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
      .tens(bus.min_tens), .ones(bus.min_ones), .carry(min_carry)
   );

   bcd_mod_counter #(.MAX_TENS(HOUR_MAX_TENS), .MAX_ONES(HOUR_MAX_ONES)) u_hour (
      .clk(clk), .rst(rst), .inc(hour_inc), .clr(1'b0),
      .tens(bus.hour_tens), .ones(bus.hour_ones), .carry(hour_carry_unused)
   );

   assign bus.tick_1hz = tick_q;
   assign bus.colon    = (pre_cnt >= COLON_LIM);

`ifdef ALARM_EN
   logic [15:0] cur_hm;
   logic [15:0] alarm_hm;
   logic        alarm_q;

   assign cur_hm = {bus.hour_tens, bus.hour_ones, bus.min_tens, bus.min_ones};

   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_hm <= '0;
         alarm_q  <= 1'b0;
      end else begin
         if (bus.alarm_store) begin
            alarm_hm <= cur_hm;
         end
         alarm_q <= bus.alarm_arm && (cur_hm == alarm_hm);
      end
   end

   assign bus.alarm_hit = alarm_q;
`endif

endmodule
